// File: rtl/redmule_core_data_demux.sv
// Routes the core OBI data port to N_TGT targets plus an internal MMIO/error responder, keeping responses in order.
// Request path is combinational; internal responses come 1 cycle after grant; grant is withheld when full or when switching targets.
module redmule_core_data_demux #(
  parameter int unsigned             N_TGT     = 3,
  parameter logic [N_TGT*32-1:0]     TGT_BASE  = {32'h1c040000, 32'h1c010000, 32'h00001000},
  parameter logic [N_TGT*32-1:0]     TGT_END   = {32'h1c070000, 32'h1c040000, 32'h1c000000},
  parameter int unsigned             MAX_OUTST = 2,
  parameter logic [7:0]              MMIO_TAG  = 8'h80
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  output logic                  core_gnt_o,
  input  logic [31:0]           core_addr_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  output logic [N_TGT-1:0]      tgt_req_o,
  input  logic [N_TGT-1:0]      tgt_gnt_i,
  output logic [31:0]           tgt_addr_o,
  output logic                  tgt_wen_o,
  output logic [3:0]            tgt_be_o,
  output logic [31:0]           tgt_wdata_o,
  input  logic [N_TGT-1:0]      tgt_rvalid_i,
  input  logic [N_TGT*32-1:0]   tgt_rdata_i,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_code_o,
  output logic                  putc_valid_o,
  output logic [7:0]            putc_char_o,
  output logic                  proto_err_o
);

  localparam int unsigned SEL_W = $clog2(N_TGT + 2);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [SEL_W-1:0] SEL_MMIO = SEL_W'(N_TGT);
  localparam logic [SEL_W-1:0] SEL_ERR  = SEL_W'(N_TGT + 1);

  logic [SEL_W-1:0] sel, last_sel, head;
  logic [SEL_W-1:0] fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             int_pend, int_err;
  logic             issue_ok, sel_gnt, hs, pop, head_rvalid, viol;
  logic [31:0]      head_rdata;
  logic [N_TGT-1:0] head_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = fifo_q[rptr];

  // Walk targets from the top down so the lowest matching index wins.
  always_comb begin
    sel = (core_addr_i[31:24] == MMIO_TAG) ? SEL_MMIO : SEL_ERR;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (core_addr_i >= TGT_BASE[i*32 +: 32] && core_addr_i < TGT_END[i*32 +: 32])
        sel = SEL_W'(i);
    end
  end

  always_comb begin
    issue_ok   = (cnt < CNT_W'(MAX_OUTST)) && ((cnt == '0) || (sel == last_sel));
    sel_gnt    = 1'b1;
    tgt_req_o  = '0;
    head_mask  = '0;
    head_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_gnt      = tgt_gnt_i[i];
        tgt_req_o[i] = core_req_i & issue_ok;
      end
      if (cnt != '0 && head == SEL_W'(i)) begin
        head_mask[i] = 1'b1;
        head_rdata   = tgt_rdata_i[i*32 +: 32];
      end
    end
    core_gnt_o    = issue_ok & sel_gnt;
    hs            = core_req_i & core_gnt_o;
    head_rvalid   = |(tgt_rvalid_i & head_mask);
    viol          = |(tgt_rvalid_i & ~head_mask);
    pop           = head_rvalid | int_pend;
    core_rvalid_o = pop;
    core_rdata_o  = head_rvalid ? head_rdata : 32'h0;
    core_err_o    = int_pend & int_err;
  end

  assign tgt_addr_o  = core_addr_i;
  assign tgt_wen_o   = ~core_we_i;
  assign tgt_be_o    = core_be_i;
  assign tgt_wdata_o = core_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt          <= '0;
      wptr         <= '0;
      rptr         <= '0;
      last_sel     <= '0;
      int_pend     <= 1'b0;
      int_err      <= 1'b0;
      proto_err_o  <= 1'b0;
      exit_valid_o <= 1'b0;
      exit_code_o  <= 32'h0;
      putc_valid_o <= 1'b0;
      putc_char_o  <= 8'h0;
      for (int k = 0; k < MAX_OUTST; k++) fifo_q[k] <= '0;
    end else begin
      int_pend     <= hs & (sel >= SEL_MMIO);
      int_err      <= hs & (sel == SEL_ERR);
      exit_valid_o <= 1'b0;
      putc_valid_o <= 1'b0;
      if (hs) begin
        fifo_q[wptr] <= sel;
        wptr         <= ptr_inc(wptr);
        last_sel     <= sel;
        // Byte enables are deliberately ignored for the MMIO window.
        if (sel == SEL_MMIO && core_we_i) begin
          if (core_addr_i[7:0] == 8'h00) begin
            exit_code_o  <= core_wdata_i;
            exit_valid_o <= 1'b1;
          end else if (core_addr_i[7:0] == 8'h04) begin
            putc_char_o  <= core_wdata_i[7:0];
            putc_valid_o <= 1'b1;
          end
        end
      end
      if (pop) rptr <= ptr_inc(rptr);
      if (hs && !pop)      cnt <= cnt + 1'b1;
      else if (!hs && pop) cnt <= cnt - 1'b1;
      if (viol) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_redmule_core_data_demux.sv
// Table-driven decode vectors, directed corner sequences and a randomized run against a queue-based model.
module tb_redmule_core_data_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_gnt, core_we, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_be;
  logic [2:0]  tgt_req, tgt_gnt, tgt_rvalid;
  logic [31:0] tgt_addr, tgt_wdata;
  logic        tgt_wen;
  logic [3:0]  tgt_be;
  logic [95:0] tgt_rdata;
  logic        exit_valid, putc_valid, proto_err;
  logic [31:0] exit_code;
  logic [7:0]  putc_char;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  redmule_core_data_demux dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_addr_i(core_addr),
    .core_we_i(core_we), .core_be_i(core_be), .core_wdata_i(core_wdata),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .tgt_req_o(tgt_req), .tgt_gnt_i(tgt_gnt), .tgt_addr_o(tgt_addr),
    .tgt_wen_o(tgt_wen), .tgt_be_o(tgt_be), .tgt_wdata_o(tgt_wdata),
    .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata),
    .exit_valid_o(exit_valid), .exit_code_o(exit_code),
    .putc_valid_o(putc_valid), .putc_char_o(putc_char), .proto_err_o(proto_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  gnt;
    logic [2:0]  exp_req;
    logic        exp_gnt;
    logic        exp_rv;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [2:0] gnt, input logic [2:0] rv);
    core_req = req; core_addr = addr; core_we = we; core_wdata = wdata;
    tgt_gnt = gnt; tgt_rvalid = rv;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a >= 32'h00001000 && a < 32'h1c000000) return 0;
    if (a >= 32'h1c010000 && a < 32'h1c040000) return 1;
    if (a >= 32'h1c040000 && a < 32'h1c070000) return 2;
    if (a[31:24] == 8'h80) return 3;
    return 4;
  endfunction

  vec_t vt[14];

  initial begin
    core_be = 4'hf; tgt_rdata = '0;
    vt[0]  = '{32'h00001000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h1bffffff, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'h1c000000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{32'h1c00fffc, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[4]  = '{32'h1c010000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h1c03fffc, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h1c040000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h1c06fffc, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h1c070000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{32'h00000ffc, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[10] = '{32'h80000010, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vt[11] = '{32'h40000000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[12] = '{32'h1c010000, 3'b101, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[13] = '{32'h1c040000, 3'b011, 3'b100, 1'b0, 1'b0, 1'b0};

    // Reset state
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b000);
    rst_n = 1'b0;
    #3;
    chk("rst_tgt_req", tgt_req, 3'b000);
    chk("rst_rvalid", core_rvalid, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_err", core_err, 0);
    chk("rst_exit_valid", exit_valid, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_putc_valid", putc_valid, 0);
    chk("rst_putc_char", putc_char, 0);
    chk("rst_proto_err", proto_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // Decode table: one request, then look at the following cycle's response
    for (int v = 0; v < 14; v++) begin
      drive(1'b1, vt[v].addr, 1'b0, 32'h0, vt[v].gnt, 3'b000);
      @(negedge clk);
      chk($sformatf("tab%0d_req", v), tgt_req, vt[v].exp_req);
      chk($sformatf("tab%0d_gnt", v), core_gnt, vt[v].exp_gnt);
      chk($sformatf("tab%0d_rv0", v), core_rvalid, 0);
      tick;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b000);
      @(negedge clk);
      chk($sformatf("tab%0d_rv1", v), core_rvalid, vt[v].exp_rv);
      chk($sformatf("tab%0d_err", v), core_err, vt[v].exp_err);
      chk($sformatf("tab%0d_rdata", v), core_rdata, 0);
      tick;
    end

    // Single read to target 1
    drive(1'b1, 32'h1c010000, 1'b0, 32'h0, 3'b010, 3'b000);
    @(negedge clk); chk("s1_req", tgt_req, 3'b010); chk("s1_gnt", core_gnt, 1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b010); tgt_rdata[63:32] = 32'hDEADBEEF;
    @(negedge clk); chk("s1_rv", core_rvalid, 1); chk("s1_rdata", core_rdata, 32'hDEADBEEF); chk("s1_err", core_err, 0);
    tick;

    // Back-to-back reads to target 2, third stalls on full
    drive(1'b1, 32'h1c040000, 1'b0, 32'h0, 3'b100, 3'b000);
    @(negedge clk); chk("s2_gnt_a", core_gnt, 1); tick;
    core_addr = 32'h1c040004;
    @(negedge clk); chk("s2_gnt_b", core_gnt, 1); tick;
    core_addr = 32'h1c040008;
    @(negedge clk); chk("s2_full_gnt", core_gnt, 0); chk("s2_full_req", tgt_req, 3'b000); chk("s2_rv_none", core_rvalid, 0); tick;
    tgt_rvalid = 3'b100; tgt_rdata[95:64] = 32'h11111111;
    @(negedge clk); chk("s2_rv_a", core_rvalid, 1); chk("s2_rd_a", core_rdata, 32'h11111111); chk("s2_gnt_stall", core_gnt, 0); tick;
    tgt_rdata[95:64] = 32'h22222222;
    @(negedge clk); chk("s2_rv_b", core_rvalid, 1); chk("s2_rd_b", core_rdata, 32'h22222222); chk("s2_gnt_c", core_gnt, 1); tick;
    core_req = 1'b0; tgt_rdata[95:64] = 32'h33333333;
    @(negedge clk); chk("s2_rv_c", core_rvalid, 1); chk("s2_rd_c", core_rdata, 32'h33333333); tick;
    tgt_rvalid = 3'b000;
    @(negedge clk); chk("s2_idle", core_rvalid, 0); chk("s2_proto", proto_err, 0); tick;

    // Target switch waits for the outstanding response to drain
    drive(1'b1, 32'h1c040000, 1'b0, 32'h0, 3'b110, 3'b000);
    @(negedge clk); chk("s3_gnt_a", core_gnt, 1); tick;
    core_addr = 32'h1c010000;
    @(negedge clk); chk("s3_hold_gnt", core_gnt, 0); chk("s3_hold_req", tgt_req, 3'b000); tick;
    tgt_rvalid = 3'b100;
    @(negedge clk); chk("s3_rv_a", core_rvalid, 1); chk("s3_hold_gnt2", core_gnt, 0); tick;
    tgt_rvalid = 3'b000;
    @(negedge clk); chk("s3_gnt_b", core_gnt, 1); chk("s3_req_b", tgt_req, 3'b010); tick;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b010); tgt_rdata[63:32] = 32'hCAFEBABE;
    @(negedge clk); chk("s3_rv_b", core_rvalid, 1); chk("s3_rd_b", core_rdata, 32'hCAFEBABE); tick;
    tgt_rvalid = 3'b000;

    // MMIO writes: putchar, exit, ignored offset
    drive(1'b1, 32'h80000004, 1'b1, 32'h00000041, 3'b000, 3'b000);
    @(negedge clk); chk("s4_gnt_p", core_gnt, 1); chk("s4_rv0", core_rvalid, 0); chk("s4_noreq", tgt_req, 3'b000); tick;
    core_addr = 32'h80000000; core_wdata = 32'h0;
    @(negedge clk); chk("s4_gnt_e", core_gnt, 1); chk("s4_rv_p", core_rvalid, 1); chk("s4_err_p", core_err, 0);
    chk("s4_putc_v", putc_valid, 1); chk("s4_putc_c", putc_char, 8'h41); chk("s4_exit_v0", exit_valid, 0); tick;
    core_req = 1'b0;
    @(negedge clk); chk("s4_rv_e", core_rvalid, 1); chk("s4_exit_v", exit_valid, 1); chk("s4_exit_c", exit_code, 0);
    chk("s4_putc_v0", putc_valid, 0); tick;
    drive(1'b1, 32'h80000000, 1'b1, 32'h000000A5, 3'b000, 3'b000);
    @(negedge clk); chk("s4_gnt_a5", core_gnt, 1); tick;
    core_addr = 32'h80000008; core_wdata = 32'h000000FF;
    @(negedge clk); chk("s4_exit_v2", exit_valid, 1); chk("s4_exit_a5", exit_code, 32'hA5); tick;
    core_req = 1'b0;
    @(negedge clk); chk("s4_rv_ign", core_rvalid, 1); chk("s4_ign_exit", exit_valid, 0); chk("s4_ign_putc", putc_valid, 0);
    chk("s4_hold_a5", exit_code, 32'hA5); tick;
    @(negedge clk); chk("s4_rv_end", core_rvalid, 0); tick;

    // Protocol violations and reset mid-transaction
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b001);
    @(negedge clk); chk("s6_drop", core_rvalid, 0); tick;
    tgt_rvalid = 3'b000;
    @(negedge clk); chk("s6_proto_set", proto_err, 1); tick;
    drive(1'b1, 32'h1c040000, 1'b0, 32'h0, 3'b100, 3'b000);
    @(negedge clk); chk("s6_gnt", core_gnt, 1); chk("s6_proto_hold", proto_err, 1); tick;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 3'b010);
    @(negedge clk); chk("s6_wrong_tgt", core_rvalid, 0);
    tgt_rvalid = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_proto", proto_err, 0); chk("s6_rst_rv", core_rvalid, 0);
    chk("s6_rst_exit", exit_code, 0); chk("s6_rst_req", tgt_req, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    tgt_rvalid = 3'b100;
    @(negedge clk); chk("s6_post_rst_drop", core_rvalid, 0); tick;
    drive(1'b1, 32'h1c010000, 1'b0, 32'h0, 3'b010, 3'b000);
    @(negedge clk); chk("s6_post_proto", proto_err, 1); chk("s6_cnt0_gnt", core_gnt, 1); tick;
    do_reset();

    // Randomized traffic against a queue model of outstanding accesses
    begin
      int          q[$];
      int          s, r;
      logic        ok, eg, erv, eerr, nxt_ev, nxt_pv, exp_ev, exp_pv;
      logic [2:0]  ereq;
      logic [31:0] erd, exp_ec, nxt_ec;
      logic [7:0]  exp_pc, nxt_pc;
      exp_ev = 0; exp_pv = 0; exp_ec = 0; exp_pc = 0;
      for (int c = 0; c < 600; c++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: core_addr = 32'h00001000 + {$urandom_range(0, 255), 2'b00};
          1: core_addr = 32'h1c010000 + {$urandom_range(0, 255), 2'b00};
          2: core_addr = 32'h1c040000 + {$urandom_range(0, 255), 2'b00};
          3: core_addr = 32'h80000000 + 4 * $urandom_range(0, 2);
          4: core_addr = 32'h40000000 + {$urandom_range(0, 255), 2'b00};
          default: core_addr = 32'h1c000000 + {$urandom_range(0, 255), 2'b00};
        endcase
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = $urandom_range(0, 1);
        core_wdata = $urandom;
        tgt_gnt    = 3'($urandom_range(0, 7));
        tgt_rdata  = {$urandom, $urandom, $urandom};
        tgt_rvalid = 3'b000;
        if (q.size() > 0 && q[0] < 3 && $urandom_range(0, 1) == 1) tgt_rvalid[q[0]] = 1'b1;
        @(negedge clk);
        s    = decode(core_addr);
        ok   = (q.size() < 2) && (q.size() == 0 || s == q[q.size()-1]);
        eg   = ok && ((s < 3) ? tgt_gnt[s] : 1'b1);
        ereq = '0;
        if (core_req && ok && s < 3) ereq[s] = 1'b1;
        erv  = (q.size() > 0) && (q[0] >= 3 || tgt_rvalid != 0);
        erd  = (q.size() > 0 && q[0] < 3 && tgt_rvalid != 0) ? tgt_rdata[q[0]*32 +: 32] : 32'h0;
        eerr = (q.size() > 0) && (q[0] == 4);
        chk("rnd_gnt", core_gnt, eg);
        chk("rnd_req", tgt_req, ereq);
        chk("rnd_rvalid", core_rvalid, erv);
        chk("rnd_rdata", core_rdata, erd);
        chk("rnd_err", core_err, eerr);
        chk("rnd_exit_v", exit_valid, exp_ev);
        chk("rnd_exit_c", exit_code, exp_ec);
        chk("rnd_putc_v", putc_valid, exp_pv);
        if (exp_pv) chk("rnd_putc_c", putc_char, exp_pc);
        nxt_ev = 0; nxt_pv = 0; nxt_ec = exp_ec; nxt_pc = exp_pc;
        if (erv) void'(q.pop_front());
        if (core_req && eg) begin
          q.push_back(s);
          if (s == 3 && core_we) begin
            if (core_addr[7:0] == 8'h00) begin nxt_ev = 1; nxt_ec = core_wdata; end
            else if (core_addr[7:0] == 8'h04) begin nxt_pv = 1; nxt_pc = core_wdata[7:0]; end
          end
        end
        exp_ev = nxt_ev; exp_pv = nxt_pv; exp_ec = nxt_ec; exp_pc = nxt_pc;
        tick;
      end
      chk("rnd_proto_clean", proto_err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
